// File: rtl/alu_seq_divider.sv
// Multi-cycle restoring unsigned divider for the ALU divide op (start/done handshake).
// One quotient bit per clock; divide-by-zero finishes one cycle after accept.
module alu_seq_divider #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             OverFlow,
    output logic             Carry,
    output logic             Zero,
    output logic             Negative
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic             accept;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmo_q, rmo_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic [WIDTH:0]   rem_sh;
    logic             ge;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (dz_q || cnt_q == LAST) state_d = DONE;
            DONE:    state_d = start ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == CALC);
        done      = (state_q == DONE);
        Quotient  = quo_q;
        Remainder = rmo_q;
        OverFlow  = ovf_q;
        Carry     = 1'b0;
        Zero      = zero_q;
        Negative  = quo_q[WIDTH-1];
    end

    // Shifted remainder needs WIDTH+1 bits; the restored result is always < B so fits WIDTH bits.
    always_comb begin
        accept = start && (state_q != CALC);
        rem_sh = {rem_q, dvd_q[WIDTH-1]};
        ge     = (rem_sh >= {1'b0, div_q});
        rem_nx = ge ? (rem_sh[WIDTH-1:0] - div_q) : rem_sh[WIDTH-1:0];
        quo_nx = {dvd_q[WIDTH-2:0], ge};

        cnt_d  = cnt_q;
        rem_d  = rem_q;
        dvd_d  = dvd_q;
        div_d  = div_q;
        dz_d   = dz_q;
        quo_d  = quo_q;
        rmo_d  = rmo_q;
        ovf_d  = ovf_q;
        zero_d = zero_q;

        if (accept) begin
            cnt_d = '0;
            rem_d = '0;
            dvd_d = A;
            div_d = B;
            dz_d  = (B == '0);
        end else if (state_q == CALC) begin
            if (dz_q) begin
                quo_d  = '1;
                rmo_d  = dvd_q;
                ovf_d  = 1'b1;
                zero_d = 1'b0;
            end else begin
                rem_d = rem_nx;
                dvd_d = quo_nx;
                cnt_d = (cnt_q == LAST) ? cnt_q : cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    quo_d  = quo_nx;
                    rmo_d  = rem_nx;
                    ovf_d  = 1'b0;
                    zero_d = (quo_nx == '0);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            dvd_q  <= '0;
            div_q  <= '0;
            dz_q   <= 1'b0;
            quo_q  <= '0;
            rmo_q  <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            dvd_q  <= dvd_d;
            div_q  <= div_d;
            dz_q   <= dz_d;
            quo_q  <= quo_d;
            rmo_q  <= rmo_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

endmodule

// File: tb/tb_alu_seq_divider.sv
// Self-checking bench for alu_seq_divider against a plain-arithmetic reference model.
module tb_alu_seq_divider;

    localparam int W = 18;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;
    logic         OverFlow;
    logic         Carry;
    logic         Zero;
    logic         Negative;

    int n_cmp = 0;
    int n_bad = 0;

    alu_seq_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .OverFlow  (OverFlow),
        .Carry     (Carry),
        .Zero      (Zero),
        .Negative  (Negative)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: {quotient, remainder, OverFlow, Carry, Zero, Negative}
    function automatic logic [2*W+3:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q;
        logic [W-1:0] r;
        if (b == 0) begin
            q = {W{1'b1}};
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r, (b == 0), 1'b0, (q == 0), q[W-1]};
    endfunction

    function automatic int exp_lat(input logic [W-1:0] b);
        return (b == 0) ? 1 : W;
    endfunction

    // Launch one operation and wait for done; lat is cycles from accept to done, -1 on timeout.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int bcnt, output bit ovl);
        lat  = -1;
        bcnt = 0;
        ovl  = 1'b0;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = W'($urandom());
        B = W'($urandom());
        for (int m = 0; m < W + 6; m++) begin
            if (busy && done) ovl = 1'b1;
            if (done) begin
                lat = m;
                break;
            end
            if (busy) bcnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        #12;
        n_cmp++;
        if ({busy, done, Quotient, Remainder, OverFlow, Carry, Zero, Negative} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b Q=%0h R=%0h flags=%b%b%b%b required all 0",
                     busy, done, Quotient, Remainder, OverFlow, Carry, Zero, Negative);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_result(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                                input int lat, input int bcnt, input bit ovl);
        logic [2*W+3:0] e;
        e = ref_div(a, b);
        n_cmp++;
        if (lat !== exp_lat(b)) begin
            n_bad++;
            $display("FAIL %s_latency: got %0d required %0d (A=%0h B=%0h)", name, lat, exp_lat(b), a, b);
        end
        n_cmp++;
        if (bcnt !== exp_lat(b) || ovl) begin
            n_bad++;
            $display("FAIL %s_busy: got %0d busy cycles overlap=%0b required %0d overlap=0",
                     name, bcnt, ovl, exp_lat(b));
        end
        n_cmp++;
        if ({Quotient, Remainder, OverFlow, Carry, Zero, Negative} !== e) begin
            n_bad++;
            $display("FAIL %s_result: A=%0h B=%0h got Q=%0h R=%0h flags=%b%b%b%b required Q=%0h R=%0h flags=%b",
                     name, a, b, Quotient, Remainder, OverFlow, Carry, Zero, Negative,
                     e[2*W+3:W+4], e[W+3:4], e[3:0]);
        end
    endtask

    task automatic test_basic();
        int lat, bcnt;
        bit ovl;
        run_op(20, 5, lat, bcnt, ovl);
        check_result("div_20_5", 20, 5, lat, bcnt, ovl);
        run_op(50, 0, lat, bcnt, ovl);
        check_result("div_by_zero", 50, 0, lat, bcnt, ovl);
        n_cmp++;
        if (Quotient !== 18'h3FFFF || Negative !== 1'b1 || OverFlow !== 1'b1) begin
            n_bad++;
            $display("FAIL div0_const: got Q=%0h N=%b V=%b required Q=3ffff N=1 V=1", Quotient, Negative, OverFlow);
        end
    endtask

    task automatic test_edge_values();
        int lat, bcnt;
        bit ovl;
        run_op(3, 7, lat, bcnt, ovl);
        check_result("div_3_7", 3, 7, lat, bcnt, ovl);
        n_cmp++;
        if (Zero !== 1'b1 || Quotient !== '0) begin
            n_bad++;
            $display("FAIL zero_flag: got Z=%b Q=%0h required Z=1 Q=0", Zero, Quotient);
        end
        run_op(18'h3FFFF, 1, lat, bcnt, ovl);
        check_result("div_max_1", 18'h3FFFF, 1, lat, bcnt, ovl);
        run_op(18'h3FFFF, 18'h3FFFF, lat, bcnt, ovl);
        check_result("div_max_max", 18'h3FFFF, 18'h3FFFF, lat, bcnt, ovl);
        run_op(18'h20000, 18'h3FFFF, lat, bcnt, ovl);
        check_result("div_msb_max", 18'h20000, 18'h3FFFF, lat, bcnt, ovl);
    endtask

    task automatic test_ignore_start();
        int first, pulses;
        logic [W-1:0] q, r;
        first = -1; pulses = 0; q = '0; r = '0;
        @(negedge clk);
        A = 100; B = 7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int m = 0; m < W + 25; m++) begin
            if (m == 5) begin A = 1; B = 1; start = 1'b1; end
            if (m == 6) start = 1'b0;
            if (done) begin
                pulses++;
                if (first < 0) begin first = m; q = Quotient; r = Remainder; end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (first !== W || pulses !== 1) begin
            n_bad++;
            $display("FAIL ignore_start_done: got first=%0d pulses=%0d required first=%0d pulses=1", first, pulses, W);
        end
        n_cmp++;
        if (q !== 14 || r !== 2) begin
            n_bad++;
            $display("FAIL ignore_start_result: got Q=%0d R=%0d required Q=14 R=2", q, r);
        end
    endtask

    task automatic test_reset_abort();
        int pulses, lat, bcnt;
        bit ovl;
        pulses = 0;
        @(negedge clk);
        A = 1000; B = 3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, Quotient, Remainder, OverFlow, Carry, Zero, Negative} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got busy=%b done=%b Q=%0h R=%0h flags=%b%b%b%b required all 0",
                     busy, done, Quotient, Remainder, OverFlow, Carry, Zero, Negative);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int m = 0; m < W + 10; m++) begin
            if (done || busy) pulses++;
            @(negedge clk);
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_bad++;
            $display("FAIL abort_no_done: got %0d active cycles after reset required 0", pulses);
        end
        run_op(9, 3, lat, bcnt, ovl);
        check_result("after_reset_9_3", 9, 3, lat, bcnt, ovl);
    endtask

    task automatic test_back_to_back();
        int lat1, lat2;
        bit held_bad;
        lat1 = -1; lat2 = -1; held_bad = 1'b0;
        @(negedge clk);
        A = 20; B = 5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int m = 0; m < W + 6; m++) begin
            if (done) begin lat1 = m; break; end
            @(negedge clk);
        end
        A = 17; B = 4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = W'($urandom()); B = W'($urandom());
        n_cmp++;
        if (lat1 !== W || {busy, done, Quotient, Remainder} !== {1'b1, 1'b0, W'(4), W'(0)}) begin
            n_bad++;
            $display("FAIL b2b_accept: got lat1=%0d busy=%b done=%b Q=%0d R=%0d required lat1=%0d busy=1 done=0 Q=4 R=0",
                     lat1, busy, done, Quotient, Remainder, W);
        end
        for (int m = 0; m < W + 6; m++) begin
            if (done) begin lat2 = m; break; end
            if (Quotient !== 4 || Remainder !== 0) held_bad = 1'b1;
            @(negedge clk);
        end
        n_cmp++;
        if (lat2 !== W || held_bad) begin
            n_bad++;
            $display("FAIL b2b_hold: got lat2=%0d held_bad=%0b required lat2=%0d held_bad=0", lat2, held_bad, W);
        end
        n_cmp++;
        if (Quotient !== 4 || Remainder !== 1 || Zero !== 1'b0 || OverFlow !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_result: got Q=%0d R=%0d Z=%b V=%b required Q=4 R=1 Z=0 V=0",
                     Quotient, Remainder, Zero, OverFlow);
        end
    endtask

    task automatic test_random();
        int lat, bcnt;
        bit ovl;
        logic [W-1:0] a, b;
        for (int i = 0; i < 25; i++) begin
            a = W'($urandom());
            case (i % 5)
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                2:       b = a >> $urandom_range(0, 4);
                default: b = W'($urandom());
            endcase
            run_op(a, b, lat, bcnt, ovl);
            check_result("random", a, b, lat, bcnt, ovl);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edge_values();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
